// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a framed host byte stream and writes words
// through the memory write port, holding the core in reset until a checksum-valid image lands.
`timescale 1ns/1ps
module imem_loader #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_start,
    input  logic [7:0]        iw_byte,
    input  logic              iw_byte_valid,
    output logic              ow_byte_ready,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    output logic              ow_cpu_rst,
    output logic              ow_busy,
    output logic              ow_done,
    output logic              ow_err
);

    localparam int BPW  = (DATA_W + 7) / 8;
    localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [7:0] MAGIC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAGIC,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q;
    logic [7:0]          cntLo_q;
    logic [CNT_W-1:0]    wordsLeft_q;
    logic [BI_W-1:0]     byteIdx_q;
    logic [BPW*8-1:0]    wordBuf_q;
    logic [BPW*8-1:0]    wordBuf_d;
    logic [ADDR_W-1:0]   wordAddr_q;
    logic [7:0]          csum_q;

    logic                inFrame;
    logic                xfer;
    logic                lastByte;
    logic                lastWord;
    logic [15:0]         hdrCount;

    assign inFrame       = (state_q == S_MAGIC) || (state_q == S_CNT_LO) ||
                           (state_q == S_CNT_HI) || (state_q == S_DATA) ||
                           (state_q == S_CSUM);
    assign ow_byte_ready = inFrame;
    assign ow_busy       = inFrame;
    assign xfer          = iw_byte_valid && inFrame;
    assign lastByte      = (byteIdx_q == BI_W'(BPW - 1));
    assign lastWord      = (wordsLeft_q == CNT_W'(1));
    assign hdrCount      = {iw_byte, cntLo_q};

    // Byte k of the word under assembly lands in bits [8k+7:8k]
    always_comb begin
        wordBuf_d = wordBuf_q;
        for (int k = 0; k < BPW; k++) begin
            if (byteIdx_q == BI_W'(k)) begin
                wordBuf_d[8*k +: 8] = iw_byte;
            end
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q      <= S_IDLE;
            cntLo_q      <= '0;
            wordsLeft_q  <= '0;
            byteIdx_q    <= '0;
            wordBuf_q    <= '0;
            wordAddr_q   <= '0;
            csum_q       <= '0;
            ow_mem_we    <= 1'b0;
            ow_mem_addr  <= '0;
            ow_mem_wdata <= '0;
            ow_cpu_rst   <= 1'b1;
            ow_done      <= 1'b0;
            ow_err       <= 1'b0;
        end else begin
            ow_mem_we <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (iw_start) begin
                        state_q     <= S_MAGIC;
                        ow_cpu_rst  <= 1'b1;
                        ow_done     <= 1'b0;
                        ow_err      <= 1'b0;
                        wordAddr_q  <= '0;
                        csum_q      <= '0;
                        byteIdx_q   <= '0;
                        wordsLeft_q <= '0;
                        wordBuf_q   <= '0;
                        cntLo_q     <= '0;
                    end
                end
                S_MAGIC: begin
                    if (xfer) begin
                        if (iw_byte == MAGIC_BYTE) begin
                            state_q <= S_CNT_LO;
                        end else begin
                            state_q <= S_ERR;
                            ow_err  <= 1'b1;
                        end
                    end
                end
                S_CNT_LO: begin
                    if (xfer) begin
                        cntLo_q <= iw_byte;
                        state_q <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (xfer) begin
                        wordsLeft_q <= CNT_W'(hdrCount);
                        state_q     <= (hdrCount == 16'd0) ? S_CSUM : S_DATA;
                    end
                end
                // Final byte of each word schedules a one-cycle write of the assembled word
                S_DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ iw_byte;
                        if (lastByte) begin
                            ow_mem_we    <= 1'b1;
                            ow_mem_addr  <= wordAddr_q;
                            ow_mem_wdata <= wordBuf_d[DATA_W-1:0];
                            wordAddr_q   <= wordAddr_q + ADDR_W'(1);
                            byteIdx_q    <= '0;
                            wordBuf_q    <= '0;
                            wordsLeft_q  <= wordsLeft_q - CNT_W'(1);
                            if (lastWord) begin
                                state_q <= S_CSUM;
                            end
                        end else begin
                            byteIdx_q <= byteIdx_q + BI_W'(1);
                            wordBuf_q <= wordBuf_d;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        if (iw_byte == csum_q) begin
                            state_q    <= S_DONE;
                            ow_done    <= 1'b1;
                            ow_cpu_rst <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            ow_err  <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: frames are modelled as byte lists, expected
// writes and final status are queued at issue time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 24;
    localparam int CNT_W  = 16;
    localparam int BPW    = (DATA_W + 7) / 8;

    // Status encoding used by the scoreboard: {done, err, cpu_rst}
    localparam logic [2:0] ST_DONE = 3'b100;
    localparam logic [2:0] ST_ERR  = 3'b011;

    logic              iw_clk = 1'b0;
    logic              iw_rst;
    logic              iw_start;
    logic [7:0]        iw_byte;
    logic              iw_byte_valid;
    logic              ow_byte_ready;
    logic              ow_mem_we;
    logic [ADDR_W-1:0] ow_mem_addr;
    logic [DATA_W-1:0] ow_mem_wdata;
    logic              ow_cpu_rst;
    logic              ow_busy;
    logic              ow_done;
    logic              ow_err;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] expAddrQ[$];
    logic [DATA_W-1:0] expDataQ[$];
    logic [2:0]        expStatusQ[$];
    logic [7:0]        payloadQ[$];
    bit                noiseEn = 1'b0;
    bit                prevDoneErr = 1'b0;

    always #5 iw_clk = ~iw_clk;

    imem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .iw_clk       (iw_clk),
        .iw_rst       (iw_rst),
        .iw_start     (iw_start),
        .iw_byte      (iw_byte),
        .iw_byte_valid(iw_byte_valid),
        .ow_byte_ready(ow_byte_ready),
        .ow_mem_we    (ow_mem_we),
        .ow_mem_addr  (ow_mem_addr),
        .ow_mem_wdata (ow_mem_wdata),
        .ow_cpu_rst   (ow_cpu_rst),
        .ow_busy      (ow_busy),
        .ow_done      (ow_done),
        .ow_err       (ow_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes on every write pulse and expected status on each end of frame
    always @(negedge iw_clk) begin
        if (iw_rst) begin
            prevDoneErr <= 1'b0;
        end else begin
            if (ow_mem_we) begin
                if (expAddrQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'(ow_mem_addr), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("write_addr", 32'(ow_mem_addr), 32'(expAddrQ.pop_front()));
                    checkOutput("write_data", 32'(ow_mem_wdata), 32'(expDataQ.pop_front()));
                end
            end
            if ((ow_done || ow_err) && !prevDoneErr) begin
                if (expStatusQ.size() == 0) begin
                    checkOutput("unexpected_status", {29'd0, ow_done, ow_err, ow_cpu_rst}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("status", {29'd0, ow_done, ow_err, ow_cpu_rst}, 32'(expStatusQ.pop_front()));
                end
                checkOutput("writes_pending_at_status", 32'(expAddrQ.size()), 32'd0);
            end
            prevDoneErr <= ow_done || ow_err;
        end
    end

    // Sends one byte, optionally preceded by a random valid gap with stray start pulses
    task automatic applyStimulus(input logic [7:0] b);
        int gap;
        int guard;
        gap = noiseEn ? int'($urandom_range(0, 5)) : 0;
        for (int i = 0; i < gap; i++) begin
            iw_byte_valid = 1'b0;
            iw_start      = noiseEn && ($urandom_range(0, 3) == 0);
            iw_byte       = 8'($urandom);
            @(negedge iw_clk);
        end
        iw_start      = 1'b0;
        iw_byte       = b;
        iw_byte_valid = 1'b1;
        guard = 0;
        while (!ow_byte_ready && guard < 50) begin
            @(negedge iw_clk);
            guard++;
        end
        if (guard >= 50) begin
            checkOutput("ready_timeout", 32'(ow_byte_ready), 32'd1);
        end
        @(negedge iw_clk);
        iw_byte_valid = 1'b0;
    endtask

    task automatic pulseStart();
        iw_start = 1'b1;
        @(negedge iw_clk);
        iw_start = 1'b0;
    endtask

    task automatic waitStatus();
        int guard;
        guard = 0;
        while (!(ow_done || ow_err) && guard < 30) begin
            @(negedge iw_clk);
            guard++;
        end
        if (guard >= 30) begin
            checkOutput("status_timeout", {30'd0, ow_done, ow_err}, 32'd1);
        end else begin
            checkOutput("ready_after_end", 32'(ow_byte_ready), 32'd0);
            checkOutput("busy_after_end", 32'(ow_busy), 32'd0);
        end
        @(negedge iw_clk);
    endtask

    // Reference model: words are little-endian byte groups, checksum is XOR of payload bytes
    task automatic queueExpected(input logic [7:0] magic, input int cnt, input logic [7:0] csumXor,
                                 output logic [7:0] csumByte);
        logic [7:0]        csum;
        logic [DATA_W-1:0] word;
        csum = 8'h00;
        if (magic != 8'hA5) begin
            expStatusQ.push_back(ST_ERR);
        end else begin
            for (int w = 0; w < cnt; w++) begin
                word = '0;
                for (int k = 0; k < BPW; k++) begin
                    word = word | (DATA_W'(payloadQ[w*BPW+k]) << (8 * k));
                    csum = csum ^ payloadQ[w*BPW+k];
                end
                expAddrQ.push_back(ADDR_W'(w));
                expDataQ.push_back(word);
            end
            expStatusQ.push_back((csumXor == 8'h00) ? ST_DONE : ST_ERR);
        end
        csumByte = csum ^ csumXor;
    endtask

    task automatic sendBody(input int cnt, input logic [7:0] csumByte);
        applyStimulus(8'(cnt));
        applyStimulus(8'(cnt >> 8));
        for (int i = 0; i < cnt * BPW; i++) begin
            applyStimulus(payloadQ[i]);
        end
        applyStimulus(csumByte);
    endtask

    task automatic runFrame(input logic [7:0] magic, input int cnt, input logic [7:0] csumXor);
        logic [7:0] csumByte;
        queueExpected(magic, cnt, csumXor, csumByte);
        pulseStart();
        applyStimulus(magic);
        if (magic == 8'hA5) begin
            sendBody(cnt, csumByte);
        end
        waitStatus();
    endtask

    task automatic setExamplePayload();
        payloadQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] csumByte;
        iw_rst        = 1'b1;
        iw_start      = 1'b0;
        iw_byte       = 8'h00;
        iw_byte_valid = 1'b0;
        repeat (2) @(negedge iw_clk);
        checkOutput("rst_ready", 32'(ow_byte_ready), 32'd0);
        checkOutput("rst_we", 32'(ow_mem_we), 32'd0);
        checkOutput("rst_addr", 32'(ow_mem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(ow_mem_wdata), 32'd0);
        checkOutput("rst_cpu_rst", 32'(ow_cpu_rst), 32'd1);
        checkOutput("rst_flags", {29'd0, ow_busy, ow_done, ow_err}, 32'd0);
        iw_rst = 1'b0;
        @(negedge iw_clk);

        setExamplePayload();
        runFrame(8'hA5, 2, 8'h00);
        runFrame(8'h5A, 0, 8'h00);
        setExamplePayload();
        runFrame(8'hA5, 2, 8'h01);

        // Empty image, with the start pulse coinciding with a valid byte that must be ignored
        payloadQ.delete();
        queueExpected(8'hA5, 0, 8'h00, csumByte);
        iw_start      = 1'b1;
        iw_byte_valid = 1'b1;
        iw_byte       = 8'hA5;
        @(negedge iw_clk);
        iw_start      = 1'b0;
        iw_byte_valid = 1'b0;
        checkOutput("busy_after_start", 32'(ow_busy), 32'd1);
        applyStimulus(8'hA5);
        sendBody(0, csumByte);
        waitStatus();

        payloadQ = '{8'hAA, 8'hBB, 8'hCC};
        runFrame(8'hA5, 1, 8'h00);

        noiseEn = 1'b1;
        setExamplePayload();
        runFrame(8'hA5, 2, 8'h00);
        noiseEn = 1'b0;

        // Reset four payload bytes into a three-word frame: only word 0 is written
        payloadQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        expAddrQ.push_back(ADDR_W'(0));
        expDataQ.push_back(DATA_W'(24'h030201));
        pulseStart();
        applyStimulus(8'hA5);
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(payloadQ[i]);
        end
        #2 iw_rst = 1'b1;
        #1;
        checkOutput("midrst_we", 32'(ow_mem_we), 32'd0);
        checkOutput("midrst_cpu_rst", 32'(ow_cpu_rst), 32'd1);
        checkOutput("midrst_flags", {29'd0, ow_busy, ow_done, ow_err}, 32'd0);
        checkOutput("midrst_ready", 32'(ow_byte_ready), 32'd0);
        @(negedge iw_clk);
        iw_rst = 1'b0;
        repeat (3) @(negedge iw_clk);
        checkOutput("midrst_writes_left", 32'(expAddrQ.size()), 32'd0);
        setExamplePayload();
        runFrame(8'hA5, 2, 8'h00);

        noiseEn = 1'b1;
        for (int f = 0; f < 20; f++) begin
            int cnt;
            logic [7:0] magic;
            logic [7:0] cx;
            cnt   = int'($urandom_range(0, 6));
            magic = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'hA5;
            cx    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            payloadQ.delete();
            for (int i = 0; i < cnt * BPW; i++) begin
                payloadQ.push_back(8'($urandom));
            end
            runFrame(magic, cnt, cx);
        end
        noiseEn = 1'b0;

        checkOutput("leftover_writes", 32'(expAddrQ.size()), 32'd0);
        checkOutput("leftover_status", 32'(expStatusQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
